// File: rtl/disp_src_if.sv
// disp_src_if: groups the operand/command/result inputs and the display
// outputs of the display-source controller.
//   sw        : test switch, level (debounced upstream)
//   cmd       : command code; 0 means "no command / clear"
//   cmd_stb   : one-cycle strobe qualifying cmd
//   op_a/op_b : live operands
//   res       : ALU result, qualified by res_valid (one-cycle strobe)
//   disp_val  : word to display, {op_a,op_b} or the latched result
//   disp_src  : 0 = operands shown, 1 = result shown
//   selout    : 1 when operands are shown (legacy display-mux select)
//   busy      : 1 while a command is pending without a result
// master: the surrounding datapath; slave: the controller.
interface disp_src_if #(
    parameter int DW    = 8,
    parameter int CMD_W = 4
);
    logic                sw;
    logic [CMD_W-1:0]    cmd;
    logic                cmd_stb;
    logic [DW-1:0]       op_a;
    logic [DW-1:0]       op_b;
    logic [2*DW-1:0]     res;
    logic                res_valid;
    logic [2*DW-1:0]     disp_val;
    logic                disp_src;
    logic                selout;
    logic                busy;

    modport master (
        output sw, cmd, cmd_stb, op_a, op_b, res, res_valid,
        input  disp_val, disp_src, selout, busy
    );

    modport slave (
        input  sw, cmd, cmd_stb, op_a, op_b, res, res_valid,
        output disp_val, disp_src, selout, busy
    );
endinterface

// File: rtl/disp_src_ctrl.sv
// disp_src_ctrl: decides whether the 7-segment path shows the operand pair
// {op_a,op_b} or the latched ALU result, tracks command/result progress,
// and under the test switch alternates operands and result every HOLD_CYC
// cycles. All outputs are registered (1-cycle latency).
// Ports:
//   clk : rising-edge clock
//   rst : synchronous reset, active-high, overrides everything
//   bus : disp_src_if slave modport (strobes/operands in, display out)
module disp_src_ctrl #(
    parameter int DW       = 8,
    parameter int CMD_W    = 4,
    parameter int HOLD_CYC = 50_000_000
) (
    input  logic      clk,
    input  logic      rst,
    disp_src_if.slave bus
);

    localparam int CNT_W = $clog2(HOLD_CYC) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HOLD_CYC - 1);

    typedef enum logic [1:0] {
        WAIT_CMD = 2'd0,
        CALC     = 2'd1,
        RESULT   = 2'd2,
        TEST     = 2'd3
    } state_t;

    state_t              state, state_d;
    state_t              ret_state, ret_d;
    state_t              lstate, lnext;
    logic [2*DW-1:0]     res_q, res_d;
    logic [CNT_W-1:0]    scan_cnt, cnt_d;
    logic                scan_ph, ph_d;
    logic                show_res;
    logic [2*DW-1:0]     disp_val_d;
    logic                disp_src_d;
    logic                selout_d;
    logic                busy_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= WAIT_CMD;
            ret_state    <= WAIT_CMD;
            res_q        <= '0;
            scan_cnt     <= '0;
            scan_ph      <= 1'b0;
            bus.disp_val <= '0;
            bus.disp_src <= 1'b0;
            bus.selout   <= 1'b1;
            bus.busy     <= 1'b0;
        end else begin
            state        <= state_d;
            ret_state    <= ret_d;
            res_q        <= res_d;
            scan_cnt     <= cnt_d;
            scan_ph      <= ph_d;
            bus.disp_val <= disp_val_d;
            bus.disp_src <= disp_src_d;
            bus.selout   <= selout_d;
            bus.busy     <= busy_d;
        end
    end

    always_comb begin
        // Strobes always act on the "logical" state: the real state outside
        // TEST, the saved return state inside it. This keeps command/result
        // tracking alive while the display is scanning.
        lstate     = (state == TEST) ? ret_state : state;
        lnext      = lstate;
        res_d      = res_q;
        state_d    = state;
        ret_d      = ret_state;
        cnt_d      = '0;
        ph_d       = 1'b0;
        show_res   = 1'b0;
        disp_val_d = '0;
        disp_src_d = 1'b0;
        selout_d   = 1'b1;
        busy_d     = 1'b0;

        // A command beats a simultaneous result; the result is dropped,
        // but a clear still zeroes the latched result.
        if (bus.cmd_stb) begin
            if (bus.cmd == '0) begin
                lnext = WAIT_CMD;
                res_d = '0;
            end else begin
                lnext = CALC;
            end
        end else if (bus.res_valid && (lstate != WAIT_CMD)) begin
            lnext = RESULT;
            res_d = bus.res;
        end

        if (bus.sw) begin
            state_d = TEST;
            ret_d   = lnext;
            if (state == TEST) begin
                if (scan_cnt == CNT_LAST) begin
                    cnt_d = '0;
                    ph_d  = ~scan_ph;
                end else begin
                    cnt_d = scan_cnt + 1'b1;
                    ph_d  = scan_ph;
                end
            end
            show_res = ph_d;
        end else begin
            state_d  = lnext;
            ret_d    = lnext;
            show_res = (lnext == RESULT);
        end

        disp_val_d = show_res ? res_d : {bus.op_a, bus.op_b};
        disp_src_d = show_res;
        selout_d   = ~show_res;
        busy_d     = (lnext == CALC);
    end

endmodule

// File: tb/tb_disp_src_ctrl.sv
module tb_disp_src_ctrl;

    localparam int DW       = 8;
    localparam int CMD_W    = 4;
    localparam int HOLD_CYC = 4;

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    disp_src_if #(.DW(DW), .CMD_W(CMD_W)) bus ();

    disp_src_ctrl #(.DW(DW), .CMD_W(CMD_W), .HOLD_CYC(HOLD_CYC)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] dv,
                       input logic sel, input logic bz, input logic src);
        checks++;
        assert (bus.disp_val === dv) else begin
            failures++;
            $error("FAIL %s disp_val got=%h want=%h", tag, bus.disp_val, dv);
        end
        checks++;
        assert (bus.selout === sel) else begin
            failures++;
            $error("FAIL %s selout got=%b want=%b", tag, bus.selout, sel);
        end
        checks++;
        assert (bus.busy === bz) else begin
            failures++;
            $error("FAIL %s busy got=%b want=%b", tag, bus.busy, bz);
        end
        checks++;
        assert (bus.disp_src === src) else begin
            failures++;
            $error("FAIL %s disp_src got=%b want=%b", tag, bus.disp_src, src);
        end
    endtask

    initial begin
        checks        = 0;
        failures      = 0;
        rst           = 1'b1;
        bus.sw        = 1'b0;
        bus.cmd       = '0;
        bus.cmd_stb   = 1'b0;
        bus.op_a      = 8'h12;
        bus.op_b      = 8'h34;
        bus.res       = '0;
        bus.res_valid = 1'b0;
        tick();
        tick();
        chk("reset", 16'h0000, 1'b1, 1'b0, 1'b0);

        // 1: reset release, operands shown
        rst = 1'b0;
        tick();
        chk("t1_idle", 16'h1234, 1'b1, 1'b0, 1'b0);

        // 2: command, busy for 3 cycles, then result
        bus.cmd = 4'h1; bus.cmd_stb = 1'b1;
        tick();
        bus.cmd_stb = 1'b0;
        chk("t2_busy1", 16'h1234, 1'b1, 1'b1, 1'b0);
        tick();
        chk("t2_busy2", 16'h1234, 1'b1, 1'b1, 1'b0);
        tick();
        chk("t2_busy3", 16'h1234, 1'b1, 1'b1, 1'b0);
        bus.res = 16'h0046; bus.res_valid = 1'b1;
        tick();
        bus.res_valid = 1'b0;
        chk("t2_result", 16'h0046, 1'b0, 1'b0, 1'b1);

        // 3: scan from RESULT
        bus.sw = 1'b1;
        tick();
        chk("t3_c1", 16'h1234, 1'b1, 1'b0, 1'b0);
        for (int i = 2; i <= 4; i++) begin
            tick();
            chk($sformatf("t3_c%0d", i), 16'h1234, 1'b1, 1'b0, 1'b0);
        end
        for (int i = 5; i <= 8; i++) begin
            tick();
            chk($sformatf("t3_c%0d", i), 16'h0046, 1'b0, 1'b0, 1'b1);
        end
        tick();
        chk("t3_c9", 16'h1234, 1'b1, 1'b0, 1'b0);
        bus.sw = 1'b0;
        tick();
        chk("t3_exit", 16'h0046, 1'b0, 1'b0, 1'b1);

        // 4: command and result together in CALC; command wins
        bus.cmd = 4'h1; bus.cmd_stb = 1'b1;
        tick();
        bus.cmd_stb = 1'b0;
        chk("t4_calc", 16'h1234, 1'b1, 1'b1, 1'b0);
        bus.cmd = 4'h2; bus.cmd_stb = 1'b1;
        bus.res = 16'hBEEF; bus.res_valid = 1'b1;
        tick();
        bus.cmd_stb = 1'b0; bus.res_valid = 1'b0;
        chk("t4_collide", 16'h1234, 1'b1, 1'b1, 1'b0);
        // scan to phase 1 to expose res_q, which must still be 0046
        bus.sw = 1'b1;
        for (int i = 1; i <= 4; i++) tick();
        chk("t4_scan_ph0", 16'h1234, 1'b1, 1'b1, 1'b0);
        tick();
        chk("t4_resq_kept", 16'h0046, 1'b0, 1'b1, 1'b1);
        bus.sw = 1'b0;
        tick();
        chk("t4_back_calc", 16'h1234, 1'b1, 1'b1, 1'b0);
        bus.res = 16'h0005; bus.res_valid = 1'b1;
        tick();
        bus.res_valid = 1'b0;
        chk("t4_result", 16'h0005, 1'b0, 1'b0, 1'b1);

        // 5: result arrives during scan from CALC
        bus.cmd = 4'h3; bus.cmd_stb = 1'b1;
        tick();
        bus.cmd_stb = 1'b0;
        chk("t5_calc", 16'h1234, 1'b1, 1'b1, 1'b0);
        bus.sw = 1'b1;
        tick();
        chk("t5_c1", 16'h1234, 1'b1, 1'b1, 1'b0);
        bus.res = 16'h00AA; bus.res_valid = 1'b1;
        tick();
        bus.res_valid = 1'b0;
        chk("t5_c2", 16'h1234, 1'b1, 1'b0, 1'b0);
        tick();
        tick();
        tick();
        chk("t5_c5", 16'h00AA, 1'b0, 1'b0, 1'b1);
        bus.sw = 1'b0;
        tick();
        chk("t5_exit", 16'h00AA, 1'b0, 1'b0, 1'b1);

        // 6: reset mid-scan, then clear command in WAIT_CMD
        bus.sw = 1'b1;
        for (int i = 1; i <= 5; i++) tick();
        chk("t6_ph1", 16'h00AA, 1'b0, 1'b0, 1'b1);
        rst = 1'b1; bus.sw = 1'b0;
        tick();
        chk("t6_rst", 16'h0000, 1'b1, 1'b0, 1'b0);
        rst = 1'b0;
        bus.cmd = 4'h0; bus.cmd_stb = 1'b1;
        tick();
        bus.cmd_stb = 1'b0;
        chk("t6_clear", 16'h1234, 1'b1, 1'b0, 1'b0);
        bus.op_a = 8'h56; bus.op_b = 8'h78;
        tick();
        chk("t6_live_ops", 16'h5678, 1'b1, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/disp_src_ctrl.md
Name: disp_src_ctrl

Overview:
- Sequential display-source controller for the calculator datapath; generalised successor of the combinational test/no-command selector.
- Decides whether the 7-segment display path shows the operand pair {A,B} or the latched result.
- Tracks command/result progress with an FSM.
- Adds a timed scan mode under the test switch that alternates {A,B} and the result.
- Sits between the operand/ALU registers and the display multiplexer/decoder.

Parameters:
- DW, 8: operand width; the result and display word are 2*DW.
- CMD_W, 4: command code width; code 0 means "no command / clear".
- HOLD_CYC, 50_000_000: clk cycles per scan phase in test mode (1 s at 50 MHz); legal range is >= 1.

Ports:
- clk  in  1  system clock, rising-edge.
- rst  in  1  synchronous reset, active-high.
- sw  in  1  test switch, level-sensitive (already debounced upstream).
- cmd  in  CMD_W  command code from the keypad decoder.
- cmd_stb  in  1  one-cycle strobe; cmd is valid this cycle.
- op_a  in  DW  operand A.
- op_b  in  DW  operand B.
- res  in  2*DW  ALU result.
- res_valid  in  1  one-cycle strobe; res is valid this cycle.
- disp_val  out  2*DW  word to display: {op_a,op_b} or the latched result.
- disp_src  out  1  0 = operands, 1 = result.
- selout  out  1  1 when operands are shown (compatible meaning for the existing display mux).
- busy  out  1  1 while a command is pending and no result has arrived.

Behaviour:
- Single clock domain. rst is synchronous and active-high, and beats every other input.
- All outputs are registered. Each output reflects the state and inputs sampled on the previous rising edge, so latency is 1 cycle.
- Reset values:
  - state = WAIT_CMD, ret_state = WAIT_CMD.
  - res_q = 0, scan_cnt = 0, scan_ph = 0.
  - disp_val = 0, disp_src = 0, selout = 1, busy = 0.
- State WAIT_CMD:
  - Displays {op_a,op_b}; selout=1, busy=0.
  - cmd_stb with cmd!=0 -> CALC.
  - cmd_stb with cmd==0 -> stay.
- State CALC:
  - Displays {op_a,op_b}; selout=1, busy=1.
  - res_valid -> res_q<=res, go to RESULT.
  - cmd_stb with cmd==0 -> WAIT_CMD and res_q<=0.
  - cmd_stb with cmd!=0 -> stay in CALC (command restarted).
- State RESULT:
  - Displays res_q; selout=0, disp_src=1, busy=0.
  - cmd_stb with cmd!=0 -> CALC.
  - cmd_stb with cmd==0 -> WAIT_CMD and res_q<=0.
  - A stray res_valid updates res_q and stays in RESULT.
- State TEST:
  - Entered from any state when sw=1. The state at entry is saved in ret_state, and scan_cnt=0, scan_ph=0.
  - Phase 0 shows {op_a,op_b} with selout=1, disp_src=0.
  - Phase 1 shows res_q with selout=0, disp_src=1.
  - scan_cnt counts 0..HOLD_CYC-1. At HOLD_CYC-1 it wraps to 0 and scan_ph toggles.
  - With HOLD_CYC=1 the phase toggles every cycle.
  - While in TEST, cmd_stb and res_valid are still processed against ret_state using the WAIT_CMD/CALC/RESULT rules. They update ret_state, res_q and busy but not the display phase.
  - sw=0 -> go to ret_state next cycle. Display follows that state's rule; scan counters are held at 0.
- Priority within a cycle: rst > sw entry/exit > cmd_stb > res_valid.
  - cmd_stb and res_valid in the same cycle: the command wins and the result is discarded, since res_q is unchanged.
  - Exception: a clear command (cmd==0) still zeroes res_q.
- op_a and op_b are not latched. The operand display tracks them live with 1-cycle latency.
- Counter width is $clog2(HOLD_CYC)+1 bits. There is no overflow at the maximum parameter.
- Reset mid-scan or mid-CALC: all state returns to the reset values on the next edge.

Test Plan:
Benches use DW=8 and HOLD_CYC=4.
1. Reset release with op_a=8'h12, op_b=8'h34, no strobes -> disp_val=16'h1234, selout=1, busy=0, disp_src=0.
2. cmd_stb with cmd=4'h1, then 3 cycles later res_valid with res=16'h0046 -> busy=1 for the 3 cycles. One cycle after res_valid: disp_val=16'h0046, selout=0, busy=0.
3. From RESULT (res_q=16'h0046), raise sw:
   - Cycles 1-4 show 16'h1234 (selout=1).
   - Cycles 5-8 show 16'h0046 (selout=0).
   - Then 16'h1234 again.
   - Drop sw -> next cycle shows 16'h0046, selout=0.
4. In CALC, pulse cmd_stb (cmd=4'h2) and res_valid (res=16'hBEEF) in the same cycle -> stays in CALC, busy=1, res_q unchanged. A later res_valid with 16'h0005 -> display 16'h0005.
5. In TEST from CALC, pulse res_valid with res=16'h00AA -> the scan result phase shows 16'h00AA. Drop sw -> RESULT with 16'h00AA, busy=0.
6. Assert rst mid-scan (phase 1) -> next edge: disp_val=0, selout=1, busy=0, state WAIT_CMD. Then cmd_stb with cmd=0 -> stays in WAIT_CMD showing the operands.
